// File: rtl/alu_md_if.sv
// Operation/result handshake bundle for alu_md.
// The DUT side uses the slave modport; the producer/consumer uses master.
interface alu_md_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport slave (
    input  in_valid, op, a, b, c, out_ready,
    output in_ready, out_valid, result, hi, lo, busy
  );

  modport master (
    output in_valid, op, a, b, c, out_ready,
    input  in_ready, out_valid, result, hi, lo, busy
  );
endinterface

// File: rtl/alu_md.sv
// ALU with HI/LO registers and an iterative multiply/divide unit.
// Plain ALU ops finish in one cycle; MULT/DIV iterate one bit per clock on operand magnitudes.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic     clk,
  input logic     rst_n,
  alu_md_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_e;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLLV = 5'd7;
  localparam logic [4:0] OP_SRLV = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_SLL  = 5'd10;
  localparam logic [4:0] OP_SRL  = 5'd11;
  localparam logic [4:0] OP_SRAV = 5'd12;
  localparam logic [4:0] OP_SLTU = 5'd13;
  localparam logic [4:0] OP_MULT = 5'd14;
  localparam logic [4:0] OP_MULTU = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_DIVU = 5'd17;
  localparam logic [4:0] OP_MFHI = 5'd18;
  localparam logic [4:0] OP_MFLO = 5'd19;
  localparam logic [4:0] OP_MTHI = 5'd20;
  localparam logic [4:0] OP_MTLO = 5'd21;

  function automatic logic [WIDTH-1:0] alu_f(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic [SHW-1:0] c);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLLV: r = b << a[SHW-1:0];
      OP_SRLV: r = b >> a[SHW-1:0];
      OP_SRA:  r = $signed(b) >>> c;
      OP_SLL:  r = b << c;
      OP_SRL:  r = b >> c;
      OP_SRAV: r = $signed(b) >>> a[SHW-1:0];
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mlo_q, mlo_d, opd_q, opd_d, dvd_q, dvd_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             rdy_q, rdy_d, ov_q, ov_d;

  logic             in_ready_s, accept_s, sgn_s, a_neg_s, b_neg_s, div_ge_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, mul_acc_s, mul_lo_s, div_acc_s, div_lo_s;
  logic [WIDTH:0]   mul_sum_s, div_sh_s;
  logic [2*WIDTH-1:0] prod_s;

  assign in_ready_s    = rdy_q && (state_q == IDLE) && (!ov_q || bus.out_ready);
  assign accept_s      = in_ready_s && bus.in_valid;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = (state_q != IDLE);

  // Operand magnitudes plus one shift-add and one restoring-divide iteration.
  always_comb begin
    sgn_s     = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg_s   = sgn_s && bus.a[WIDTH-1];
    b_neg_s   = sgn_s && bus.b[WIDTH-1];
    a_mag_s   = neg_if(a_neg_s, bus.a);
    b_mag_s   = neg_if(b_neg_s, bus.b);
    mul_sum_s = {1'b0, acc_q} + (mlo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    mul_acc_s = mul_sum_s[WIDTH:1];
    mul_lo_s  = {mul_sum_s[0], mlo_q[WIDTH-1:1]};
    prod_s    = neg_q ? -{mul_acc_s, mul_lo_s} : {mul_acc_s, mul_lo_s};
    div_sh_s  = {acc_q, mlo_q[WIDTH-1]};
    div_ge_s  = (div_sh_s >= {1'b0, opd_q});
    div_acc_s = div_ge_s ? (div_sh_s[WIDTH-1:0] - opd_q) : div_sh_s[WIDTH-1:0];
    div_lo_s  = {mlo_q[WIDTH-2:0], div_ge_s};
  end

  // Next-state: accept in IDLE, iterate in MUL/DIV, publish HI/LO on the final step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mlo_d   = mlo_q;
    opd_d   = opd_q;
    dvd_d   = dvd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rdy_d   = 1'b1;
    if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end else begin
      ov_d = ov_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              state_d = MUL;
              cnt_d   = {SHW{1'b0}};
              acc_d   = {WIDTH{1'b0}};
              mlo_d   = b_mag_s;
              opd_d   = a_mag_s;
              neg_d   = a_neg_s ^ b_neg_s;
            end
            OP_DIV, OP_DIVU: begin
              state_d = DIV;
              cnt_d   = {SHW{1'b0}};
              acc_d   = {WIDTH{1'b0}};
              mlo_d   = a_mag_s;
              opd_d   = b_mag_s;
              neg_d   = a_neg_s ^ b_neg_s;
              rneg_d  = a_neg_s;
              dz_d    = (bus.b == {WIDTH{1'b0}});
              dvd_d   = bus.a;
            end
            OP_MFHI: begin
              res_d = hi_q;
              ov_d  = 1'b1;
            end
            OP_MFLO: begin
              res_d = lo_q;
              ov_d  = 1'b1;
            end
            OP_MTHI: begin
              hi_d  = bus.a;
              res_d = {WIDTH{1'b0}};
              ov_d  = 1'b1;
            end
            OP_MTLO: begin
              lo_d  = bus.a;
              res_d = {WIDTH{1'b0}};
              ov_d  = 1'b1;
            end
            default: begin
              res_d = alu_f(bus.op, bus.a, bus.b, bus.c);
              ov_d  = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        acc_d = mul_acc_s;
        mlo_d = mul_lo_s;
        if (cnt_q == {SHW{1'b1}}) begin
          state_d = IDLE;
          hi_d    = prod_s[2*WIDTH-1:WIDTH];
          lo_d    = prod_s[WIDTH-1:0];
          res_d   = {WIDTH{1'b0}};
          ov_d    = 1'b1;
        end else begin
          state_d = MUL;
        end
      end
      DIV: begin
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        acc_d = div_acc_s;
        mlo_d = div_lo_s;
        if (cnt_q == {SHW{1'b1}}) begin
          state_d = IDLE;
          // A zero divisor bypasses the iteration result: all-ones quotient, dividend as remainder.
          if (dz_q) begin
            hi_d = dvd_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = neg_if(rneg_q, div_acc_s);
            lo_d = neg_if(neg_q, div_lo_s);
          end
          res_d = {WIDTH{1'b0}};
          ov_d  = 1'b1;
        end else begin
          state_d = DIV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {SHW{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      mlo_q   <= {WIDTH{1'b0}};
      opd_q   <= {WIDTH{1'b0}};
      dvd_q   <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      rdy_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mlo_q   <= mlo_d;
      opd_q   <= opd_d;
      dvd_q   <= dvd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rdy_q   <= rdy_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: cycle-level reference model compared every negedge,
// directed literal checks, randomized traffic with random backpressure, and a 16-bit instance.
module tb_alu_md;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   rand_or = 1'b0;

  always #5 clk = ~clk;

  alu_md_if #(.WIDTH(32), .SHW(5)) bus ();
  alu_md_if #(.WIDTH(16), .SHW(4)) bus16 ();

  alu_md #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_md #(.WIDTH(16), .SHW(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  // reference model state (value after the most recent rising edge)
  logic        m_rdy = 1'b0, m_ov = 1'b0, exp_rdy;
  logic [31:0] m_res = 32'd0, m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] c);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return ~(a | b);
      5'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd7:  return b << a[4:0];
      5'd8:  return b >> a[4:0];
      5'd9:  return sb >>> c;
      5'd10: return b << c;
      5'd11: return b >> c;
      5'd12: return sb >>> a[4:0];
      5'd13: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // compare DUT against the model, then advance the model for the coming edge
  initial begin
    logic        acc;
    logic [31:0] ma, mb;
    logic [4:0]  mop, mc;
    longint      sq, sr;
    logic [63:0] prod;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_rdy = 1'b0; m_ov = 1'b0; m_res = 32'd0; m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0;
      end
      exp_rdy = m_rdy && (m_cnt == 0) && (!m_ov || bus.out_ready);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("busy", 32'(bus.busy), 32'(m_cnt > 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("result", bus.result, m_res);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      if (rst_n) begin
        acc = bus.in_valid && exp_rdy;
        ma = bus.a; mb = bus.b; mop = bus.op; mc = bus.c;
        if (m_ov && bus.out_ready) m_ov = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_res = 32'd0; m_ov = 1'b1;
          end
        end else if (acc) begin
          case (mop)
            5'd14: begin
              prod = longint'($signed(ma)) * longint'($signed(mb));
              {p_hi, p_lo} = prod; m_cnt = 32;
            end
            5'd15: begin
              prod = {32'd0, ma} * {32'd0, mb};
              {p_hi, p_lo} = prod; m_cnt = 32;
            end
            5'd16: begin
              if (mb == 32'd0) begin
                p_hi = ma; p_lo = 32'hFFFF_FFFF;
              end else begin
                sq = longint'($signed(ma)) / longint'($signed(mb));
                sr = longint'($signed(ma)) % longint'($signed(mb));
                p_lo = sq[31:0]; p_hi = sr[31:0];
              end
              m_cnt = 32;
            end
            5'd17: begin
              if (mb == 32'd0) begin
                p_hi = ma; p_lo = 32'hFFFF_FFFF;
              end else begin
                p_lo = ma / mb; p_hi = ma % mb;
              end
              m_cnt = 32;
            end
            5'd18: begin m_res = m_hi; m_ov = 1'b1; end
            5'd19: begin m_res = m_lo; m_ov = 1'b1; end
            5'd20: begin m_hi = ma; m_res = 32'd0; m_ov = 1'b1; end
            5'd21: begin m_lo = ma; m_res = 32'd0; m_ov = 1'b1; end
            default: begin m_res = ref_alu(mop, ma, mb, mc); m_ov = 1'b1; end
          endcase
        end
        m_rdy = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] c, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.c = c;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      tick();
      if (got) break;
      waits++;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom); bus.a = $urandom; bus.b = $urandom; bus.c = 5'($urandom);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w, n;
    logic [4:0] rop;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 5'd0; bus.a = 32'd0; bus.b = 32'd0; bus.c = 5'd0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.op = 5'd0;
    bus16.a = 16'd0; bus16.b = 16'd0; bus16.c = 4'd0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    tick();
    chk("in_ready_after_edge", 32'(bus.in_ready), 32'd1);

    send(5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, w);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_wrap", bus.result, 32'h0000_0000);
    send(5'd9, 32'd0, 32'h8000_0000, 5'd4, w);
    chk("sra", bus.result, 32'hF800_0000);
    send(5'd13, 32'd1, 32'hFFFF_FFFF, 5'd0, w);
    chk("sltu", bus.result, 32'd1);
    send(5'd6, 32'd1, 32'hFFFF_FFFF, 5'd0, w);
    chk("slt", bus.result, 32'd0);

    send(5'd14, 32'hFFFF_FFFE, 32'd3, 5'd0, w);
    count_busy(n);
    chk("mult_busy_cycles", 32'(n), 32'd32);
    chk("mult_valid", 32'(bus.out_valid), 32'd1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    chk("mult_result", bus.result, 32'd0);
    send(5'd15, 32'hFFFF_FFFE, 32'd3, 5'd0, w);
    count_busy(n);
    chk("multu_hi", bus.hi, 32'h0000_0002);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

    send(5'd16, -32'sd7, 32'd2, 5'd0, w);
    count_busy(n);
    chk("div_busy_cycles", 32'(n), 32'd32);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    send(5'd17, 32'd7, 32'd0, 5'd0, w);
    count_busy(n);
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'd7);
    send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, w);
    count_busy(n);
    chk("divmin_lo", bus.lo, 32'h8000_0000);
    chk("divmin_hi", bus.hi, 32'd0);

    tick();
    bus.out_ready = 1'b0;
    send(5'd0, 32'd5, 32'd6, 5'd0, w);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", bus.result, 32'd11);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    send(5'd1, 32'd20, 32'd3, 5'd0, w);
    chk("bp_same_cycle_accept", 32'(w), 32'd0);
    chk("bp_next_result", bus.result, 32'd17);
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);

    send(5'd17, 32'd100, 32'd7, 5'd0, w);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    send(5'd20, 32'h0000_1234, 32'd0, 5'd0, w);
    send(5'd18, 32'd0, 32'd0, 5'd0, w);
    chk("mthi_mfhi", bus.result, 32'h0000_1234);

    rand_or = 1'b1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 9) < 2) rop = 5'($urandom_range(14, 17));
      else rop = 5'($urandom_range(0, 31));
      send(rop, pick_val(), pick_val(), 5'($urandom), w);
    end
    rand_or = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && (bus.busy || bus.out_valid); i++) tick();
    chk("drain_idle", 32'(bus.busy || bus.out_valid), 32'd0);

    bus16.op = 5'd15; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.in_valid = 1'b1;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      w = int'(bus16.in_ready);
      tick();
      if (w != 0) break;
    end
    bus16.in_valid = 1'b0;
    chk("w16_accept", 32'(w), 32'd1);
    n = 0;
    while (bus16.busy && n < 100) begin
      n++;
      tick();
    end
    chk("w16_busy_cycles", 32'(n), 32'd16);
    chk("w16_valid", 32'(bus16.out_valid), 32'd1);
    chk("w16_hi", 32'(bus16.hi), 32'h0000_FFFE);
    chk("w16_lo", 32'(bus16.lo), 32'h0000_0001);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
